inst_fetch_bridge: RTL and testbench

- Sits between the core's instruction-fetch port (pc/ce out, instruction in) and a variable-latency instruction memory with a request/grant/response handshake.
- Holds the last fetched instruction in a tagged line buffer and returns it with zero added latency on a hit.
- On a miss, raises a stall request to the pipeline controller and fetches the word from memory.
- A watchdog converts lost responses into a NOP plus a sticky error flag.

---
 rtl/inst_fetch_bridge_pkg.sv | 21 ++
 rtl/inst_fetch_bridge_ifb_line.sv | 53 +++++
 rtl/inst_fetch_bridge.sv | 181 ++++++++++++++++++
 tb/tb_inst_fetch_bridge.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_bridge_pkg.sv
// Shared types and constants for the instruction fetch bridge.
package inst_fetch_bridge_pkg;

  localparam int InstAddrBusW = 32;
  localparam int InstBusW     = 32;

  typedef logic [InstAddrBusW-1:0] inst_addr_bus_t;
  typedef logic [InstBusW-1:0]     inst_bus_t;
  typedef logic [7:0]              ifb_cnt_bus_t;

  localparam inst_bus_t NopInst = 32'h0000_0000;

  typedef enum logic [2:0] {
    IFB_IDLE    = 3'd0,
    IFB_REQ     = 3'd1,
    IFB_WAIT    = 3'd2,
    IFB_PF_REQ  = 3'd3,
    IFB_PF_WAIT = 3'd4
  } ifb_state_e;

endpackage

// File: rtl/inst_fetch_bridge_ifb_line.sv
// One tagged instruction line: valid/tag/data with write, invalidate and
// a combinational tag compare against the current fetch address.
module ifb_line #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              inv_i,
  input  logic [ADDR_W-1:0] wtag_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Write has priority over invalidate.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (we_i) begin
      valid_d = 1'b1;
      tag_d   = wtag_i;
      data_d  = wdata_i;
    end else if (inv_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign hit_o  = valid_q & (tag_q == addr_i);
  assign data_o = data_q;

endmodule

// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: line buffer in front of a req/gnt/rvalid memory.
// Optional next-line prefetch enabled by defining IFB_PREFETCH_EN.
module inst_fetch_bridge
  import inst_fetch_bridge_pkg::*;
#(
  parameter int                ADDR_W   = InstAddrBusW,
  parameter int                DATA_W   = InstBusW,
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NopInst)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic [DATA_W-1:0] cpu_inst_o,
  output logic              stallreq_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              fetch_err_o
);

  localparam ifb_cnt_bus_t TimeoutCnt = ifb_cnt_bus_t'(TIMEOUT);

  ifb_state_e        state_q, state_d;
  ifb_cnt_bus_t      cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              mem_req_q, mem_req_d;
  logic              err_q, err_d;
  logic              time_up, hit;
  logic              dl_we, dl_hit, pf_hit;
  logic [ADDR_W-1:0] dl_wtag;
  logic [DATA_W-1:0] dl_wdata, dl_data, pf_data;

  ifb_line #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_demand_line (
    .clk(clk), .rst(rst), .we_i(dl_we), .inv_i(1'b0), .wtag_i(dl_wtag),
    .wdata_i(dl_wdata), .addr_i(cpu_addr_i), .hit_o(dl_hit), .data_o(dl_data)
  );

`ifdef IFB_PREFETCH_EN
  logic pf_we, pf_inv;

  ifb_line #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_prefetch_line (
    .clk(clk), .rst(rst), .we_i(pf_we), .inv_i(pf_inv), .wtag_i(req_addr_q),
    .wdata_i(mem_rdata_i), .addr_i(cpu_addr_i), .hit_o(pf_hit), .data_o(pf_data)
  );
`else
  assign pf_hit  = 1'b0;
  assign pf_data = NOP_WORD;
`endif

  assign cnt_inc = cnt_q + 8'd1;
  assign time_up = (cnt_inc == TimeoutCnt);
  assign hit     = cpu_ce_i & (dl_hit | pf_hit);

  // Next-state, line writes and request bookkeeping.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_addr_d = req_addr_q;
    err_d      = err_q;
    dl_we      = 1'b0;
    dl_wtag    = req_addr_q;
    dl_wdata   = mem_rdata_i;
`ifdef IFB_PREFETCH_EN
    pf_we      = 1'b0;
    pf_inv     = 1'b0;
`endif
    case (state_q)
      IFB_IDLE: begin
`ifdef IFB_PREFETCH_EN
        // Promote a prefetch hit into the demand line and chase the next word.
        if (cpu_ce_i && !dl_hit && pf_hit) begin
          dl_we      = 1'b1;
          dl_wtag    = cpu_addr_i;
          dl_wdata   = pf_data;
          req_addr_d = cpu_addr_i + ADDR_W'(32'd4);
          state_d    = IFB_PF_REQ;
        end else
`endif
        if (cpu_ce_i && !hit) begin
          req_addr_d = cpu_addr_i;
          state_d    = IFB_REQ;
        end else begin
          state_d = IFB_IDLE;
        end
      end
      IFB_REQ: begin
        if (mem_gnt_i) begin
          cnt_d   = 8'd0;
          state_d = IFB_WAIT;
        end else begin
          state_d = IFB_REQ;
        end
      end
      IFB_WAIT: begin
        cnt_d = cnt_inc;
        if (mem_rvalid_i || time_up) begin
          dl_we = 1'b1;
          if (mem_rvalid_i) begin
            dl_wdata = mem_rdata_i;
          end else begin
            dl_wdata = NOP_WORD;
            err_d    = 1'b1;
          end
`ifdef IFB_PREFETCH_EN
          req_addr_d = req_addr_q + ADDR_W'(32'd4);
          state_d    = IFB_PF_REQ;
`else
          state_d    = IFB_IDLE;
`endif
        end else begin
          state_d = IFB_WAIT;
        end
      end
`ifdef IFB_PREFETCH_EN
      IFB_PF_REQ: begin
        if (mem_gnt_i) begin
          cnt_d   = 8'd0;
          state_d = IFB_PF_WAIT;
        end else begin
          state_d = IFB_PF_REQ;
        end
      end
      IFB_PF_WAIT: begin
        cnt_d = cnt_inc;
        if (mem_rvalid_i) begin
          pf_we   = 1'b1;
          state_d = IFB_IDLE;
        end else if (time_up) begin
          pf_inv  = 1'b1;
          state_d = IFB_IDLE;
        end else begin
          state_d = IFB_PF_WAIT;
        end
      end
`endif
      default: state_d = IFB_IDLE;
    endcase
    mem_req_d = (state_d == IFB_REQ) || (state_d == IFB_PF_REQ);
  end

  // State and request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IFB_IDLE;
      cnt_q      <= 8'd0;
      req_addr_q <= '0;
      mem_req_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_addr_q <= req_addr_d;
      mem_req_q  <= mem_req_d;
      err_q      <= err_d;
    end
  end

  // Zero-latency instruction return from whichever line matches.
  always_comb begin
    cpu_inst_o = NOP_WORD;
    if (!cpu_ce_i) begin
      cpu_inst_o = NOP_WORD;
    end else if (dl_hit) begin
      cpu_inst_o = dl_data;
    end else if (pf_hit) begin
      cpu_inst_o = pf_data;
    end else begin
      cpu_inst_o = NOP_WORD;
    end
  end

  assign stallreq_o  = cpu_ce_i & ~hit;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = req_addr_q;
  assign fetch_err_o = err_q;

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Vector-table and scoreboard bench for inst_fetch_bridge (TIMEOUT = 4).
module tb_inst_fetch_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_ce_i = 1'b0;
  logic [31:0] cpu_addr_i = 32'd0;
  logic [31:0] cpu_inst_o;
  logic        stallreq_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'd0;
  logic        fetch_err_o;

  always #5 clk = ~clk;

  inst_fetch_bridge #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i),
    .cpu_inst_o(cpu_inst_o), .stallreq_o(stallreq_o), .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .fetch_err_o(fetch_err_o)
  );

  typedef struct {
    logic        ce;
    logic [31:0] addr;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        stall;
    logic [31:0] inst;
    logic        req;
    logic [31:0] maddr;
    logic        err;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  vec_t        vecs[$];
  vec_t        exp_q[$];
  logic [31:0] req_exp_q[$];
  logic        prev_req = 1'b0;

  function automatic vec_t mk(logic ce, logic [31:0] a, logic g, logic rv, logic [31:0] rd,
                              logic st, logic [31:0] in, logic rq, logic [31:0] ma, logic er);
    vec_t v;
    v.ce = ce; v.addr = a; v.gnt = g; v.rv = rv; v.rdata = rd;
    v.stall = st; v.inst = in; v.req = rq; v.maddr = ma; v.err = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(posedge clk);
    #1;
    cpu_ce_i     = v.ce;
    cpu_addr_i   = v.addr;
    mem_gnt_i    = v.gnt;
    mem_rvalid_i = v.rv;
    mem_rdata_i  = v.rdata;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    chk($sformatf("row%0d.stall", idx), {31'd0, stallreq_o}, {31'd0, e.stall});
    chk($sformatf("row%0d.inst", idx), cpu_inst_o, e.inst);
    chk($sformatf("row%0d.req", idx), {31'd0, mem_req_o}, {31'd0, e.req});
    chk($sformatf("row%0d.maddr", idx), mem_addr_o, e.maddr);
    chk($sformatf("row%0d.err", idx), {31'd0, fetch_err_o}, {31'd0, e.err});
  endtask

  // Request scoreboard: each new request must match the next expected address.
  always @(negedge clk) begin
    if (mem_req_o && !prev_req) begin
      if (req_exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_req: got addr %h expected no request", mem_addr_o);
      end else begin
        chk("req_addr", mem_addr_o, req_exp_q.pop_front());
      end
    end
    prev_req = mem_req_o;
  end

  initial begin
    // Reset state, sampled while rst is held.
    @(negedge clk);
    chk("rst.stall", {31'd0, stallreq_o}, 32'd0);
    chk("rst.inst", cpu_inst_o, 32'd0);
    chk("rst.req", {31'd0, mem_req_o}, 32'd0);
    chk("rst.maddr", mem_addr_o, 32'd0);
    chk("rst.err", {31'd0, fetch_err_o}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

`ifndef IFB_PREFETCH_EN
    req_exp_q.push_back(32'h0);
    req_exp_q.push_back(32'h4);
    req_exp_q.push_back(32'h100);
    req_exp_q.push_back(32'h200);
    req_exp_q.push_back(32'h300);
    req_exp_q.push_back(32'h300);

    // Cold fetch of 0x0, fill 3 cycles after grant.
    vecs.push_back(mk(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0, 1'b0, 1'b1, 32'h3402_0001, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0));
    // Hits; a stray rvalid in IDLE must not disturb the line.
    vecs.push_back(mk(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h3402_0001, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h3402_0001, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h3402_0001, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h3402_0001, 1'b0, 32'h0, 1'b0));
    // ce low: no stall, no request, NOP out.
    vecs.push_back(mk(1'b0, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    // Grant withheld for 5 cycles.
    vecs.push_back(mk(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h4, 1'b0));
    vecs.push_back(mk(1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h4, 1'b0));
    // Redirect to 0x100 during WAIT: fill still tags 0x4.
    vecs.push_back(mk(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h4, 1'b0));
    vecs.push_back(mk(1'b1, 32'h100, 1'b0, 1'b1, 32'hAAAA_AAAA, 1'b1, 32'h0, 1'b0, 32'h4, 1'b0));
    vecs.push_back(mk(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h4, 1'b0));
    vecs.push_back(mk(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 1'b0, 32'hAAAA_AAAA, 1'b1, 32'h100, 1'b0));
    vecs.push_back(mk(1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h100, 1'b0));
    // rvalid on the last allowed WAIT cycle wins over the timeout.
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h100, 1'b0));
    vecs.push_back(mk(1'b1, 32'h100, 1'b0, 1'b1, 32'h1234_5678, 1'b1, 32'h0, 1'b0, 32'h100, 1'b0));
    vecs.push_back(mk(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h1234_5678, 1'b0, 32'h100, 1'b0));
    // Lost response: abort after 4 WAIT cycles.
    vecs.push_back(mk(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h100, 1'b0));
    vecs.push_back(mk(1'b1, 32'h200, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h200, 1'b0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h200, 1'b0));
    vecs.push_back(mk(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h200, 1'b1));
    vecs.push_back(mk(1'b0, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h200, 1'b1));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset clears the sticky error.
    @(posedge clk);
    #1;
    cpu_ce_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst2.err", {31'd0, fetch_err_o}, 32'd0);
    chk("rst2.maddr", mem_addr_o, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset in WAIT, then a late rvalid must be ignored.
    apply(mk(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0), 100);
    apply(mk(1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h300, 1'b0), 101);
    @(posedge clk);
    #1;
    cpu_ce_i  = 1'b0;
    mem_gnt_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst.req", {31'd0, mem_req_o}, 32'd0);
    chk("midrst.maddr", mem_addr_o, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    apply(mk(1'b0, 32'h300, 1'b0, 1'b1, 32'h0000_0BAD, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0), 102);
    apply(mk(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0), 103);
    apply(mk(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h300, 1'b0), 104);
`else
    req_exp_q.push_back(32'h8);
    req_exp_q.push_back(32'hC);
    req_exp_q.push_back(32'h10);
    // Fill 0x8, prefetch 0xC, then 0xC hits and 0x10 is requested.
    apply(mk(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0), 200);
    apply(mk(1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h8, 1'b0), 201);
    apply(mk(1'b1, 32'h8, 1'b0, 1'b1, 32'h8888, 1'b1, 32'h0, 1'b0, 32'h8, 1'b0), 202);
    apply(mk(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0, 32'h8888, 1'b1, 32'hC, 1'b0), 203);
    apply(mk(1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 1'b0, 32'h8888, 1'b1, 32'hC, 1'b0), 204);
    apply(mk(1'b1, 32'h8, 1'b0, 1'b1, 32'hCCCC, 1'b0, 32'h8888, 1'b0, 32'hC, 1'b0), 205);
    apply(mk(1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 1'b0, 32'hCCCC, 1'b0, 32'hC, 1'b0), 206);
    apply(mk(1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 1'b0, 32'hCCCC, 1'b1, 32'h10, 1'b0), 207);
`endif

    @(posedge clk);
    @(negedge clk);
    chk("req_left", req_exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
